cdc_handshake_tx: RTL and testbench

//  Source-domain end of a 4-phase req/ack clock-domain crossing. Accepts a word locally and drives level req_o plus
//  a stable data_o bus to a foreign-clock receiver. Watches the receiver's asynchronous ack_i through an internal

---
 rtl/cdc_pkg.sv | 8 +
 rtl/cdc_sync_chain.sv | 29 ++
 rtl/cdc_handshake_tx.sv | 158 +++++++++++++++
 tb/tb_cdc_handshake_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and constants for the 4-phase req/ack clock-domain-crossing blocks.
package cdc_pkg;

   typedef enum logic [1:0] {CDC_IDLE, CDC_REQ_HI, CDC_ACK_LO} cdc_tx_state_t;

   localparam int unsigned CDC_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync_chain.sv
// N-stage single-bit synchronizer with asynchronous active-high reset to 0.
module cdc_sync_chain
   import cdc_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_stages
      $error("cdc_sync_chain: SYNC_STAGES must be >= %0d", CDC_MIN_SYNC_STAGES);
   end

   logic [SYNC_STAGES-1:0] stages;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stages <= '0;
      end else begin
         stages <= {stages[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-domain side of a 4-phase req/ack crossing; holds data_o stable while the handshake runs.
// Optional per-phase ack timeout is built when CDC_TX_TIMEOUT_EN is defined.
module cdc_handshake_tx
   import cdc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  send_valid_i,
   input  logic [DATA_WIDTH-1:0] send_data_i,
   output logic                  send_ready_o,
   output logic                  req_o,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  ack_i,
   output logic                  done_o,
   output logic                  timeout_o
);

   if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_stages
      $error("cdc_handshake_tx: SYNC_STAGES must be >= %0d", CDC_MIN_SYNC_STAGES);
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("cdc_handshake_tx: TIMEOUT_CYCLES must be >= 2");
   end

   localparam int unsigned SW = $clog2(SYNC_STAGES + 1);

   logic          ack_s;
   logic [SW-1:0] start_cnt;
   logic          start_ok;
   logic          accept;
   cdc_tx_state_t state;

   cdc_sync_chain #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_ack_sync (
      .clk  (clk),
      .reset(reset),
      .d    (ack_i),
      .q    (ack_s)
   );

   // Hold off sends until the ack chain has flushed its reset value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_cnt <= '0;
      end else if (!start_ok) begin
         start_cnt <= start_cnt + 1'b1;
      end
   end

   assign start_ok     = (start_cnt == SW'(SYNC_STAGES));
   assign send_ready_o = start_ok & (state == CDC_IDLE) & ~ack_s & ~done_o;
   assign accept       = send_valid_i & send_ready_o;

`ifdef CDC_TX_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] to_cnt;
   logic          tmr_off;   // timer disarmed for the rest of this transfer
   logic          aborted;   // req phase timed out: completion is not reported

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= CDC_IDLE;
         req_o     <= 1'b0;
         data_o    <= '0;
         done_o    <= 1'b0;
         timeout_o <= 1'b0;
         to_cnt    <= '0;
         tmr_off   <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         done_o    <= 1'b0;
         timeout_o <= 1'b0;
         case (state)
            CDC_IDLE: begin
               to_cnt <= '0;
               if (accept) begin
                  data_o  <= send_data_i;
                  req_o   <= 1'b1;
                  tmr_off <= 1'b0;
                  aborted <= 1'b0;
                  state   <= CDC_REQ_HI;
               end
            end
            CDC_REQ_HI: begin
               to_cnt <= to_cnt + 1'b1;
               if (ack_s) begin
                  req_o  <= 1'b0;
                  to_cnt <= '0;
                  state  <= CDC_ACK_LO;
               end else if (to_cnt == TLIM) begin
                  req_o     <= 1'b0;
                  timeout_o <= 1'b1;
                  tmr_off   <= 1'b1;
                  aborted   <= 1'b1;
                  to_cnt    <= '0;
                  state     <= CDC_ACK_LO;
               end
            end
            CDC_ACK_LO: begin
               to_cnt <= to_cnt + 1'b1;
               if (!ack_s) begin
                  done_o <= ~aborted;
                  to_cnt <= '0;
                  state  <= CDC_IDLE;
               end else if (!tmr_off && to_cnt == TLIM) begin
                  timeout_o <= 1'b1;
                  tmr_off   <= 1'b1;
               end
            end
            default: state <= CDC_IDLE;
         endcase
      end
   end
`else
   assign timeout_o = 1'b0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= CDC_IDLE;
         req_o  <= 1'b0;
         data_o <= '0;
         done_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            CDC_IDLE: begin
               if (accept) begin
                  data_o <= send_data_i;
                  req_o  <= 1'b1;
                  state  <= CDC_REQ_HI;
               end
            end
            CDC_REQ_HI: begin
               if (ack_s) begin
                  req_o <= 1'b0;
                  state <= CDC_ACK_LO;
               end
            end
            CDC_ACK_LO: begin
               if (!ack_s) begin
                  done_o <= 1'b1;
                  state  <= CDC_IDLE;
               end
            end
            default: state <= CDC_IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: table-driven transfers, scoreboard on req_o rise,
// plus hand-written back-to-back, stale-ack, reset-mid-op and timeout sequences.
module tb_cdc_handshake_tx;

   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          send_valid = 1'b0;
   logic [DW-1:0] send_data = '0;
   logic          send_ready;
   logic          req_o;
   logic [DW-1:0] data_o;
   logic          ack_i = 1'b0;
   logic          done_o;
   logic          timeout_o;

   int n_chk  = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int exp_done_total = 0;
   logic req_prev = 1'b0;
   logic [DW-1:0] exp_q[$];

   cdc_handshake_tx #(
      .DATA_WIDTH    (DW),
      .SYNC_STAGES   (2),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .send_valid_i(send_valid),
      .send_data_i (send_data),
      .send_ready_o(send_ready),
      .req_o       (req_o),
      .data_o      (data_o),
      .ack_i       (ack_i),
      .done_o      (done_o),
      .timeout_o   (timeout_o)
   );

   always #5 clk = ~clk;

   initial begin
      #400us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: each req_o rise must present the oldest queued word; ack_s must be low then.
   always @(negedge clk) begin
      if (req_o && !req_prev) begin
         if (exp_q.size() == 0) check("sb_unexpected_req", 1, 0);
         else check("sb_data", data_o, exp_q.pop_front());
         check("sb_req_while_ack", dut.ack_s, 0);
      end
      if (done_o) done_cnt++;
      req_prev = req_o;
   end

   task automatic do_reset(input logic ack_level);
      send_valid = 1'b0;
      ack_i = ack_level;
      #3 reset = 1'b1;
      #1;
      check("reset_outputs", {send_ready, req_o, done_o, timeout_o, data_o}, '0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic check_startup();
      check("startup_ready_c0", send_ready, 0);
      tick();
      check("startup_ready_c1", send_ready, 0);
      tick();
      check("startup_ready_c2", send_ready, 1);
   endtask

   task automatic wait_ready_and_accept(input logic [DW-1:0] d);
      int n;
      send_data  = d;
      send_valid = 1'b1;
      n = 0;
      while (!send_ready && n < 100) begin tick(); n++; end
      check("accept_wait", send_ready, 1);
      check("req_low_before_accept", req_o, 0);
      exp_q.push_back(d);
      tick();
      send_valid = 1'b0;
      send_data  = $urandom();
      check("req_rise_c1", req_o, 1);
   endtask

   task automatic do_xfer(input logic [DW-1:0] d, input int ack_dly,
                          input int exp_fall, input int exp_done);
      int n;
      int unstable;
      unstable = 0;
      wait_ready_and_accept(d);
      check("data_after_accept", data_o, d);
      repeat (ack_dly) begin
         tick();
         if (data_o !== d || req_o !== 1'b1) unstable++;
      end
      ack_i = 1'b1;
      n = 0;
      while (req_o && n < 20) begin
         tick(); n++;
         if (data_o !== d) unstable++;
      end
      check("req_fall_latency", n, exp_fall);
      ack_i = 1'b0;
      n = 0;
      while (!done_o && n < 20) begin
         tick(); n++;
         if (data_o !== d) unstable++;
      end
      check("done_latency", n, exp_done);
      check("data_stable", unstable, 0);
      check("ready_low_on_done", send_ready, 0);
      tick();
      check("done_is_pulse", done_o, 0);
      check("ready_after_done", send_ready, 1);
      exp_done_total++;
   endtask

   task automatic responder(input int k);
      int n;
      for (int i = 0; i < k; i++) begin
         n = 0;
         while (!req_o && n < 200) begin tick(); n++; end
         check("rsp_req_seen", req_o, 1);
         repeat (2) tick();
         ack_i = 1'b1;
         n = 0;
         while (req_o && n < 50) begin tick(); n++; end
         check("rsp_req_drop", req_o, 0);
         ack_i = 1'b0;
      end
   endtask

   task automatic back_to_back();
      logic [DW-1:0] words[3];
      int n;
      int d0;
      words = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
      d0 = done_cnt;
      fork
         responder(3);
         begin
            send_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
               send_data = words[i];
               n = 0;
               while (!send_ready && n < 200) begin tick(); n++; end
               check("b2b_accept_wait", send_ready, 1);
               exp_q.push_back(words[i]);
               tick();
            end
            send_valid = 1'b0;
         end
      join
      repeat (8) tick();
      check("b2b_done_count", done_cnt - d0, 3);
      check("b2b_queue_drained", exp_q.size(), 0);
      exp_done_total += 3;
   endtask

   typedef struct {
      logic [DW-1:0] data;
      int            ack_dly;
      int            exp_fall;  // edges from ack_i rise to req_o low: 2 sync + 1 FSM
      int            exp_done;  // edges from ack_i fall to done_o: 2 sync + 1 FSM
   } vec_t;

   vec_t vecs[5];

   initial begin
      int n;
      int errs;
      int d0;

      vecs[0] = '{32'hDEAD_BEEF, 5, 3, 3};
      vecs[1] = '{32'h0000_0000, 0, 3, 3};
      vecs[2] = '{32'hFFFF_FFFF, 1, 3, 3};
      vecs[3] = '{32'h1234_5678, 9, 3, 3};
      vecs[4] = '{32'h8000_0001, 2, 3, 3};

      // Reset values and startup blanking.
      do_reset(1'b0);
      check_startup();

      foreach (vecs[i]) do_xfer(vecs[i].data, vecs[i].ack_dly, vecs[i].exp_fall, vecs[i].exp_done);

      back_to_back();

      // Stale high ack held through reset release blocks sends.
      do_reset(1'b1);
      errs = 0;
      repeat (5) begin
         tick();
         if (send_ready !== 1'b0) errs++;
      end
      check("stale_ready_held_low", errs, 0);
      ack_i = 1'b0;
      tick();
      check("stale_ready_c1", send_ready, 0);
      tick();
      check("stale_ready_c2", send_ready, 1);
      do_xfer(32'h5A5A_A5A5, 3, 3, 3);

      // Asynchronous reset in the middle of REQ_HI.
      wait_ready_and_accept(32'hCAFE_F00D);
      repeat (3) tick();
      check("midop_req_before", req_o, 1);
      #3 reset = 1'b1;
      #1;
      check("midop_req_async", req_o, 0);
      check("midop_data_async", data_o, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_startup();
      do_xfer(32'h0BAD_CAFE, 4, 3, 3);

`ifdef CDC_TX_TIMEOUT_EN
      // Ack never rises: req phase times out, no completion reported.
      d0 = done_cnt;
      wait_ready_and_accept(32'h7777_0000);
      n = 0;
      while (!timeout_o && n < 40) begin tick(); n++; end
      check("to_latency", n, 16);
      check("to_req_drop", req_o, 0);
      check("to_no_done", done_o, 0);
      tick();
      check("to_pulse_one_cycle", timeout_o, 0);
      check("to_ready_after_drop", send_ready, 1);
      repeat (4) tick();
      check("to_done_not_pulsed", done_cnt - d0, 0);
`else
      // Ack withheld: the FSM must wait indefinitely without timing out.
      wait_ready_and_accept(32'h7777_0000);
      errs = 0;
      repeat (1000) begin
         tick();
         if (req_o !== 1'b1 || timeout_o !== 1'b0) errs++;
      end
      check("hold_req_no_timeout", errs, 0);
      ack_i = 1'b1;
      n = 0;
      while (req_o && n < 20) begin tick(); n++; end
      check("hold_req_fall", n, 3);
      ack_i = 1'b0;
      n = 0;
      while (!done_o && n < 20) begin tick(); n++; end
      check("hold_done", n, 3);
      exp_done_total++;
      repeat (3) tick();
`endif

      check("done_total", done_cnt, exp_done_total);
      check("sb_all_consumed", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
